// File: rtl/cic_interp.sv
// cic_interp: five-stage CIC interpolator, 20-bit signed in at 1/R rate, 20-bit signed out every osc_clk
//   osc_clk   : sole clock, rising edge
//   rst_n     : asynchronous active-low reset
//   Gain      : output scaling, effective right shift = base_shift - Gain (clamped at 0)
//   d_in      : signed input sample
//   din_valid : d_in holds a sample
//   din_ready : one-cycle input slot strobe, once every interpolation_ratio cycles
//   d_out     : signed output sample, registered every cycle
//   underrun  : one-cycle pulse after a slot that passed without a sample
// Define CIC_INTERP_SAT_EN to saturate d_out instead of truncating to the low 20 bits.
module cic_interp #(
    parameter int width               = 60,
    parameter int interpolation_ratio = 256,
    parameter int base_shift          = 32
) (
    input  logic        osc_clk,
    input  logic        rst_n,
    input  logic [7:0]  Gain,
    input  logic [19:0] d_in,
    input  logic        din_valid,
    output logic        din_ready,
    output logic [19:0] d_out,
    output logic        underrun
);
    localparam int CW = $clog2(interpolation_ratio);

    logic [CW-1:0]          r_count;
    logic                   r_ready;
    logic                   r_under;
    logic [19:0]            r_dout;
    // r_c[0] is the captured sample x, r_c[1..5] are the comb outputs
    logic signed [width-1:0] r_c [0:5];
    logic signed [width-1:0] r_cd [0:4];
    // r_cv[k] marks the cycle in which r_c[k] holds a fresh value
    logic [5:0]             r_cv;
    logic signed [width-1:0] r_i [1:5];
    logic signed [width-1:0] w_u;
    logic [7:0]             w_shift;
    logic [19:0]            w_out;

    assign din_ready = r_ready;
    assign underrun  = r_under;
    assign d_out     = r_dout;

    always_ff @(posedge osc_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_ready <= 1'b0;
            r_under <= 1'b0;
        end else begin
            r_count <= r_count + CW'(1);
            // registered so that din_ready is high exactly while count == R-1
            r_ready <= (r_count == CW'(interpolation_ratio - 2));
            r_under <= r_ready & ~din_valid;
        end
    end

    always_ff @(posedge osc_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cv <= '0;
            for (int k = 0; k <= 5; k++) r_c[k] <= '0;
            for (int k = 0; k <= 4; k++) r_cd[k] <= '0;
        end else begin
            r_cv <= {r_cv[4:0], r_ready};
            if (r_ready)
                r_c[0] <= din_valid ? {{(width-20){d_in[19]}}, d_in} : '0;
            for (int k = 1; k <= 5; k++) begin
                if (r_cv[k-1]) begin
                    r_c[k]    <= r_c[k-1] - r_cd[k-1];
                    r_cd[k-1] <= r_c[k-1];
                end
            end
        end
    end

    // zero-stuffing: the comb result enters the integrators for one cycle only
    assign w_u = r_cv[5] ? r_c[5] : '0;

    always_ff @(posedge osc_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 1; k <= 5; k++) r_i[k] <= '0;
        end else begin
            r_i[1] <= r_i[1] + w_u;
            for (int k = 2; k <= 5; k++) r_i[k] <= r_i[k] + r_i[k-1];
        end
    end

    assign w_shift = (Gain > 8'(base_shift)) ? 8'd0 : 8'(base_shift) - Gain;

`ifdef CIC_INTERP_SAT_EN
    localparam logic signed [width-1:0] MAXV = width'(524287);
    localparam logic signed [width-1:0] MINV = -width'(524288);
    logic signed [width-1:0] w_shifted;
    assign w_shifted = r_i[5] >>> w_shift;
    assign w_out = (w_shifted > MAXV) ? 20'h7FFFF :
                   (w_shifted < MINV) ? 20'h80000 : w_shifted[19:0];
`else
    assign w_out = 20'(r_i[5] >>> w_shift);
`endif

    always_ff @(posedge osc_clk or negedge rst_n) begin
        if (!rst_n) r_dout <= '0;
        else        r_dout <= w_out;
    end
endmodule
